// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port and VGA output bundle for vga_frame_reader.
interface vga_frame_reader_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] pixel_val;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       frame_start;

    // Reader side: issues addresses, drives the DAC/sync pins.
    modport master (
        output pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        input  pixel_val
    );

    // Frame-buffer / display side.
    modport slave (
        input  pixel_x, pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        output pixel_val
    );
endinterface

// File: rtl/vga_frame_reader.sv
// Free-running VGA raster generator that reads a grayscale frame buffer and
// aligns sync/blank timing with the buffer's fixed read latency.
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic                clk,
    input logic                reset,
    vga_frame_reader_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Stage 0 is aligned with pixel_x/pixel_y; the last stage drives the pins.
    localparam int unsigned PipeW   = RD_LATENCY + 2;

    // Counters are 10 bits wide, enough for totals up to 1024.
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap;

    logic       active;
    logic       hs_raw;
    logic       vs_raw;
    logic       fs_raw;
    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;
    logic       frame_start_q;

    logic [PipeW-1:0] blank_pipe_q;
    logic [PipeW-1:0] hs_pipe_q;
    logic [PipeW-1:0] vs_pipe_q;
    logic [7:0]       rgb_q, rgb_d;

    // Raster counter next state: v advances only on the h wrap.
    always_comb begin
        h_wrap  = (h_cnt_q == 10'(H_TOTAL - 1));
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Decode region/sync from the counters and select the colour for the next edge.
    always_comb begin
        active    = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
        hs_raw    = !((h_cnt_q >= 10'(H_ACTIVE + H_FP)) &&
                      (h_cnt_q <  10'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw    = !((v_cnt_q >= 10'(V_ACTIVE + V_FP)) &&
                      (v_cnt_q <  10'(V_ACTIVE + V_FP + V_SYNC)));
        fs_raw    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        pixel_x_d = active ? h_cnt_q : 10'd0;
        pixel_y_d = active ? v_cnt_q : 10'd0;
        // pixel_val is valid for the address whose blank bit sits one stage before the pins.
        rgb_d     = blank_pipe_q[PipeW-2] ? bus.pixel_val : 8'h00;
    end

    // All state: counters, address stage, sync/blank delay line and colour register.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            frame_start_q <= 1'b0;
            blank_pipe_q  <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            rgb_q         <= 8'h00;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= fs_raw;
            blank_pipe_q  <= {blank_pipe_q[PipeW-2:0], active};
            hs_pipe_q     <= {hs_pipe_q[PipeW-2:0], hs_raw};
            vs_pipe_q     <= {vs_pipe_q[PipeW-2:0], vs_raw};
            rgb_q         <= rgb_d;
        end
    end

    // Output wiring.
    always_comb begin
        bus.pixel_x     = pixel_x_q;
        bus.pixel_y     = pixel_y_q;
        bus.frame_start = frame_start_q;
        bus.vga_r       = rgb_q;
        bus.vga_g       = rgb_q;
        bus.vga_b       = rgb_q;
        bus.vga_blank_n = blank_pipe_q[PipeW-1];
        bus.vga_hs      = hs_pipe_q[PipeW-1];
        bus.vga_vs      = vs_pipe_q[PipeW-1];
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: two instances (read latency 2 and 3) on a shrunken
// raster, a latency-accurate frame-buffer model, and a cycle scoreboard.
module tb_vga_frame_reader;
    localparam int HA = 16;
    localparam int HFP = 2;
    localparam int HS = 3;
    localparam int HBP = 4;
    localparam int VA = 6;
    localparam int VFP = 1;
    localparam int VS = 2;
    localparam int VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       blank;
        logic       hs;
        logic       vs;
        logic [7:0] val;
    } st_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank;
        logic       hs;
        logic       vs;
    } out_t;

    localparam st_t RST_T = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   fb_const = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int   mh = 0;
    int   mv = 0;
    st_t  d2_q[$];
    st_t  d3_q[$];
    out_t exp2_q[$];
    out_t exp3_q[$];
    out_t ex2, ac2, ex3, ac3;

    logic [7:0] fb2_q [2];
    logic [7:0] fb3_q [3];

    vga_frame_reader_if if2 ();
    vga_frame_reader_if if3 ();

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RD_LATENCY(2)
    ) dut2 (
        .clk(clk),
        .reset(reset),
        .bus(if2)
    );

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RD_LATENCY(3)
    ) dut3 (
        .clk(clk),
        .reset(reset),
        .bus(if3)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [9:0] x, input logic [9:0] y);
        logic [7:0] t;
        t = x[7:0] + {y[3:0], 4'h0};
        return t;
    endfunction

    // Frame buffer: value for the address presented in cycle t is valid in cycle t+latency.
    always @(posedge clk) begin
        fb2_q[0] <= fb_const ? 8'hFF : pix(if2.pixel_x, if2.pixel_y);
        fb2_q[1] <= fb2_q[0];
        fb3_q[0] <= fb_const ? 8'hFF : pix(if3.pixel_x, if3.pixel_y);
        fb3_q[1] <= fb3_q[0];
        fb3_q[2] <= fb3_q[1];
    end
    assign if2.pixel_val = fb2_q[1];
    assign if3.pixel_val = fb3_q[2];

    function automatic st_t model_stage(input int h, input int v);
        st_t s;
        bit  act;
        act     = (h < HA) && (v < VA);
        s.x     = act ? 10'(h) : 10'd0;
        s.y     = act ? 10'(v) : 10'd0;
        s.fs    = (h == 0) && (v == 0);
        s.blank = act;
        s.hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
        s.vs    = !((v >= VA + VFP) && (v < VA + VFP + VS));
        s.val   = fb_const ? 8'hFF : pix(s.x, s.y);
        return s;
    endfunction

    function automatic out_t mk_out(input st_t a, input st_t d);
        logic [7:0] c;
        c = d.blank ? d.val : 8'h00;
        return {a.x, a.y, a.fs, c, c, c, d.blank, d.hs, d.vs};
    endfunction

    // One clock: drive reset, predict the post-edge outputs, push them after the edge.
    task automatic step(input bit rst);
        out_t p2, p3;
        st_t  s0;
        reset = rst;
        if (rst) begin
            mh = 0;
            mv = 0;
            d2_q.delete();
            d3_q.delete();
            repeat (3) d2_q.push_back(RST_T);
            repeat (4) d3_q.push_back(RST_T);
            p2 = mk_out(RST_T, RST_T);
            p3 = p2;
        end else begin
            s0 = model_stage(mh, mv);
            d2_q.push_back(s0);
            d3_q.push_back(s0);
            p2 = mk_out(s0, d2_q.pop_front());
            p3 = mk_out(s0, d3_q.pop_front());
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp2_q.push_back(p2);
        exp3_q.push_back(p3);
    endtask

    // Scoreboard: compare every cycle mid-period against the predicted outputs.
    always @(negedge clk) begin
        if (exp2_q.size() != 0) begin
            ex2 = exp2_q.pop_front();
            ac2 = {if2.pixel_x, if2.pixel_y, if2.frame_start, if2.vga_r, if2.vga_g, if2.vga_b,
                   if2.vga_blank_n, if2.vga_hs, if2.vga_vs};
            n_checks++;
            if (ac2 !== ex2) begin
                n_fail++;
                $display("FAIL sb_lat2 cyc=%0d got=%h exp=%h", cyc, ac2, ex2);
            end
        end
        if (exp3_q.size() != 0) begin
            ex3 = exp3_q.pop_front();
            ac3 = {if3.pixel_x, if3.pixel_y, if3.frame_start, if3.vga_r, if3.vga_g, if3.vga_b,
                   if3.vga_blank_n, if3.vga_hs, if3.vga_vs};
            n_checks++;
            if (ac3 !== ex3) begin
                n_fail++;
                $display("FAIL sb_lat3 cyc=%0d got=%h exp=%h", cyc, ac3, ex3);
            end
        end
    end

    task automatic test_reset();
        repeat (3) step(1'b1);
        n_checks++;
        if ({if2.vga_hs, if2.vga_vs, if2.vga_blank_n, if2.frame_start} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=1100",
                     {if2.vga_hs, if2.vga_vs, if2.vga_blank_n, if2.frame_start});
        end
        n_checks++;
        if ({if2.pixel_x, if2.pixel_y, if2.vga_r} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0", {if2.pixel_x, if2.pixel_y, if2.vga_r});
        end
        n_checks++;
        if ({if3.vga_hs, if3.vga_vs, if3.vga_blank_n, if3.frame_start} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_ctrl3 got=%b exp=1100",
                     {if3.vga_hs, if3.vga_vs, if3.vga_blank_n, if3.frame_start});
        end
    endtask

    task automatic test_stream();
        int fs_n = 0, fs_last = -1, fs_per = -1, fs3_first = -1, rise2 = -1, rise3 = -1;
        int hs_fall = -1, hs_per = -1, hs_low = 0, hs_low_w = -1;
        int vs_low = 0, vs_low_w = -1, run = 0, runs = 0, bad_runs = 0, hi_cnt = 0;
        int max_x = 0, max_y = 0;
        logic hs_prev = 1'b1;
        logic vs_prev = 1'b1;
        logic bl_prev = 1'b0;
        for (int i = 0; i < 2 * FRAME + HT; i++) begin
            step(1'b0);
            if (if2.frame_start === 1'b1) begin
                if (fs_last >= 0) fs_per = i - fs_last;
                fs_last = i;
                fs_n++;
            end
            if (if3.frame_start === 1'b1 && fs3_first < 0) fs3_first = i;
            if (if2.vga_blank_n === 1'b1 && rise2 < 0) rise2 = i;
            if (if3.vga_blank_n === 1'b1 && rise3 < 0) rise3 = i;
            if (hs_prev === 1'b1 && if2.vga_hs === 1'b0) begin
                if (hs_fall >= 0) hs_per = i - hs_fall;
                hs_fall = i;
            end
            if (if2.vga_hs === 1'b0) hs_low++;
            else if (hs_prev === 1'b0) begin
                hs_low_w = hs_low;
                hs_low = 0;
            end
            if (if2.vga_vs === 1'b0) vs_low++;
            else if (vs_prev === 1'b0) begin
                vs_low_w = vs_low;
                vs_low = 0;
            end
            if (if2.vga_blank_n === 1'b1) begin
                run++;
                if (i < 2 * FRAME) hi_cnt++;
            end else if (bl_prev === 1'b1) begin
                runs++;
                if (run != HA) bad_runs++;
                run = 0;
            end
            if (int'(if2.pixel_x) > max_x) max_x = int'(if2.pixel_x);
            if (int'(if2.pixel_y) > max_y) max_y = int'(if2.pixel_y);
            hs_prev = if2.vga_hs;
            vs_prev = if2.vga_vs;
            bl_prev = if2.vga_blank_n;
        end
        n_checks++;
        if (fs_per != FRAME || fs_n != 3) begin
            n_fail++;
            $display("FAIL fs_period got=%0d/%0d exp=%0d/3", fs_per, fs_n, FRAME);
        end
        n_checks++;
        if (hs_per != HT || hs_low_w != HS) begin
            n_fail++;
            $display("FAIL hs_timing got=%0d/%0d exp=%0d/%0d", hs_per, hs_low_w, HT, HS);
        end
        n_checks++;
        if (vs_low_w != VS * HT) begin
            n_fail++;
            $display("FAIL vs_low got=%0d exp=%0d", vs_low_w, VS * HT);
        end
        n_checks++;
        if (bad_runs != 0 || hi_cnt != 2 * HA * VA) begin
            n_fail++;
            $display("FAIL blank_runs got=%0d bad, %0d high exp=0, %0d",
                     bad_runs, hi_cnt, 2 * HA * VA);
        end
        n_checks++;
        if (max_x != HA - 1 || max_y != VA - 1) begin
            n_fail++;
            $display("FAIL addr_max got=%0d,%0d exp=%0d,%0d", max_x, max_y, HA - 1, VA - 1);
        end
        n_checks++;
        if (rise2 != 3 || rise3 - fs3_first != 4) begin
            n_fail++;
            $display("FAIL blank_rise got=%0d,%0d exp=3,4", rise2, rise3 - fs3_first);
        end
    endtask

    task automatic test_const_ff();
        int bad = 0, ff_seen = 0;
        fb_const = 1'b1;
        repeat (2) step(1'b1);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0);
            if (if2.vga_r !== (if2.vga_blank_n ? 8'hFF : 8'h00)) bad++;
            if (if3.vga_b !== (if3.vga_blank_n ? 8'hFF : 8'h00)) bad++;
            if (if2.vga_blank_n === 1'b1 && if2.vga_g === 8'hFF) ff_seen++;
        end
        n_checks++;
        if (bad != 0 || ff_seen != HA * VA) begin
            n_fail++;
            $display("FAIL const_ff got=%0d bad, %0d ff exp=0, %0d", bad, ff_seen, HA * VA);
        end
        fb_const = 1'b0;
        step(1'b1);
    endtask

    task automatic test_mid_reset();
        int k = 0;
        bit found = 1'b0;
        step(1'b1);
        for (int i = 0; i < 2 * FRAME && !(mh == 10 && mv == 3); i++) step(1'b0);
        repeat (3) step(1'b1);
        n_checks++;
        if ({if2.pixel_x, if2.pixel_y, if2.vga_r, if2.vga_hs, if2.vga_vs, if2.vga_blank_n,
             if2.frame_start} !== {28'd0, 4'b1100}) begin
            n_fail++;
            $display("FAIL midrst_vals got=%h exp=%h", {if2.pixel_x, if2.pixel_y, if2.vga_r,
                     if2.vga_hs, if2.vga_vs, if2.vga_blank_n, if2.frame_start}, {28'd0, 4'b1100});
        end
        step(1'b0);
        n_checks++;
        if (if2.frame_start !== 1'b1 || if3.frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_fs got=%b%b exp=11", if2.frame_start, if3.frame_start);
        end
        for (int i = 1; i <= 100 && !found; i++) begin
            step(1'b0);
            if (if2.vga_hs === 1'b0) begin
                k = i;
                found = 1'b1;
            end
        end
        n_checks++;
        if (k != HA + HFP + 3) begin
            n_fail++;
            $display("FAIL midrst_hs got=%0d exp=%0d", k, HA + HFP + 3);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_const_ff();
        test_mid_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp2_q.size() != 0 || exp3_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d,%0d exp=0,0", exp2_q.size(), exp3_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
